instruction_memory_server: RTL and testbench

Responder side of the instruction-fetch interface: a dual-read instruction memory that serves the branch-not-taken and branch-taken addresses in parallel, each with a fixed 1-cycle read latency. A host loader fills the memory through a 32-bit valid/ack stream. The loader assembles two 32-bit halves into each 64-bit instruction and writes them at auto-incrementing addresses. Sits in the MEM unit between the host/control bus and the fetch unit.

---
 rtl/instruction_memory_server.sv | 146 ++++++++++++++
 tb/tb_instruction_memory_server.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_server.sv
// Dual-read instruction memory with a 32-bit valid/ack loader that packs two halves per 64-bit word.
// Optional macro IMEM_WRITE_BYPASS_EN: reads stay live during a load and same-cycle writes are forwarded.
module instruction_memory_server #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] iAddress1,
  input  logic [ADDR_WIDTH-1:0] iAddress2,
  output logic [DATA_WIDTH-1:0] oInstruction1,
  output logic [DATA_WIDTH-1:0] oInstruction2,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH-1:0] iLoadBaseAddress,
  input  logic [ADDR_WIDTH-1:0] iLoadWordCount,
  input  logic [31:0]           iLoadData,
  input  logic                  iLoadValid,
  output logic                  oLoadAck,
  output logic                  oLoadBusy,
  output logic                  oLoadDone,
  output logic                  oAddressError
);

  localparam int unsigned HALF_WIDTH = 32;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, LOAD_LO, LOAD_HI, DONE} loadState_t;

  loadState_t state, stateNext;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [HALF_WIDTH-1:0] loHold;
  logic [DATA_WIDTH-1:0] wrWord;
  logic                  wrEn;
  logic                  loHoldEn;
  logic                  startZero;
  logic                  lastWord;
  logic                  wrInRange;
  logic                  rd1InRange;
  logic                  rd2InRange;

  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> DEPTH_LOG2) == '0;
  endfunction

  assign wrWord     = {iLoadData, loHold};
  assign wrInRange  = inRange(wrPtr);
  assign rd1InRange = inRange(iAddress1);
  assign rd2InRange = inRange(iAddress2);

  // Loader next-state and handshake decode
  always_comb begin
    stateNext = state;
    oLoadAck  = 1'b0;
    wrEn      = 1'b0;
    loHoldEn  = 1'b0;
    startZero = 1'b0;
    lastWord  = 1'b0;
    case (state)
      IDLE: begin
        if (iLoadStart) begin
          if (iLoadWordCount == '0) startZero = 1'b1;
          else                      stateNext = LOAD_LO;
        end
      end
      LOAD_LO: begin
        oLoadAck = iLoadValid;
        if (iLoadValid) begin
          loHoldEn  = 1'b1;
          stateNext = LOAD_HI;
        end
      end
      LOAD_HI: begin
        oLoadAck = iLoadValid;
        if (iLoadValid) begin
          wrEn = 1'b1;
          if (remaining == ADDR_WIDTH'(1)) begin
            lastWord  = 1'b1;
            stateNext = DONE;
          end else begin
            stateNext = LOAD_LO;
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State, loader datapath, read ports and error flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      wrPtr         <= '0;
      remaining     <= '0;
      loHold        <= '0;
      oLoadBusy     <= 1'b0;
      oLoadDone     <= 1'b0;
      oInstruction1 <= '0;
      oInstruction2 <= '0;
      oAddressError <= 1'b0;
    end else begin
      state     <= stateNext;
      oLoadBusy <= (stateNext != IDLE);
      oLoadDone <= lastWord | startZero;

      if (state == IDLE && iLoadStart) begin
        wrPtr     <= iLoadBaseAddress;
        remaining <= iLoadWordCount;
      end else if (wrEn) begin
        wrPtr     <= wrPtr + ADDR_WIDTH'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
      end

      if (loHoldEn) loHold <= iLoadData;

`ifdef IMEM_WRITE_BYPASS_EN
      if (wrEn && wrInRange && iAddress1 == wrPtr) oInstruction1 <= wrWord;
      else if (rd1InRange)                         oInstruction1 <= mem[iAddress1[DEPTH_LOG2-1:0]];
      else                                         oInstruction1 <= '0;

      if (wrEn && wrInRange && iAddress2 == wrPtr) oInstruction2 <= wrWord;
      else if (rd2InRange)                         oInstruction2 <= mem[iAddress2[DEPTH_LOG2-1:0]];
      else                                         oInstruction2 <= '0;
`else
      // Reads are blanked to NOP while the loader owns the memory
      if (oLoadBusy || !rd1InRange) oInstruction1 <= '0;
      else                          oInstruction1 <= mem[iAddress1[DEPTH_LOG2-1:0]];

      if (oLoadBusy || !rd2InRange) oInstruction2 <= '0;
      else                          oInstruction2 <= mem[iAddress2[DEPTH_LOG2-1:0]];
`endif

      if (!rd1InRange || !rd2InRange || (wrEn && !wrInRange)) oAddressError <= 1'b1;
    end
  end

  // Storage is never reset; out-of-range writes are dropped
  always_ff @(posedge Clock) begin
    if (!Reset && wrEn && wrInRange) mem[wrPtr[DEPTH_LOG2-1:0]] <= wrWord;
  end

endmodule

// File: tb/tb_instruction_memory_server.sv
// Self-checking bench for instruction_memory_server: scoreboard-driven read checks plus loader handshake checks.
module tb_instruction_memory_server;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] iAddress1 = '0;
  logic [15:0] iAddress2 = '0;
  logic [63:0] oInstruction1;
  logic [63:0] oInstruction2;
  logic        iLoadStart = 1'b0;
  logic [15:0] iLoadBaseAddress = '0;
  logic [15:0] iLoadWordCount = '0;
  logic [31:0] iLoadData = '0;
  logic        iLoadValid = 1'b0;
  logic        oLoadAck;
  logic        oLoadBusy;
  logic        oLoadDone;
  logic        oAddressError;

  instruction_memory_server dut (
    .Clock(Clock), .Reset(Reset),
    .iAddress1(iAddress1), .iAddress2(iAddress2),
    .oInstruction1(oInstruction1), .oInstruction2(oInstruction2),
    .iLoadStart(iLoadStart), .iLoadBaseAddress(iLoadBaseAddress),
    .iLoadWordCount(iLoadWordCount), .iLoadData(iLoadData), .iLoadValid(iLoadValid),
    .oLoadAck(oLoadAck), .oLoadBusy(oLoadBusy), .oLoadDone(oLoadDone),
    .oAddressError(oAddressError)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
    string       tag;
  } rdExp_t;

  rdExp_t      sb[$];
  rdExp_t      e;
  logic [63:0] shadow [int];
  int          checks = 0;
  int          failures = 0;
  logic        ack;
  logic        gapAck;

  function automatic logic [63:0] model(input logic [15:0] a);
    if (a >= 16'h0400)     return 64'h0;
    if (shadow.exists(a))  return shadow[a];
    return 64'h0;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] x1, input logic [63:0] x2, input string tag);
    rdExp_t r;
    r.e1 = x1; r.e2 = x2; r.tag = tag;
    sb.push_back(r);
  endtask

  task automatic drive_read(input logic [15:0] a1, input logic [15:0] a2, input string tag);
    iAddress1 = a1;
    iAddress2 = a2;
    push_exp(model(a1), model(a2), tag);
  endtask

  task automatic start_load(input logic [15:0] base, input logic [15:0] count);
    iLoadBaseAddress = base;
    iLoadWordCount   = count;
    iLoadStart       = 1'b1;
    step();
    iLoadStart       = 1'b0;
  endtask

  // Idle 'gaps' cycles with valid low, then present one half for one cycle
  task automatic send_half(input logic [31:0] d, input int gaps, output logic ackSeen, output logic gapSeen);
    gapSeen    = 1'b0;
    iLoadValid = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      #1;
      if (oLoadAck !== 1'b0) gapSeen = 1'b1;
      step();
    end
    iLoadData  = d;
    iLoadValid = 1'b1;
    #1;
    ackSeen = oLoadAck;
    step();
    iLoadValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    checks++; if (oInstruction1 !== 64'h0 || oInstruction2 !== 64'h0) begin failures++; $display("FAIL reset_outputs: got %h %h expected 0 0", oInstruction1, oInstruction2); end
    checks++; if ({oLoadAck, oLoadBusy, oLoadDone, oAddressError} !== 4'b0000) begin failures++; $display("FAIL reset_flags: ack/busy/done/err=%b expected 0000", {oLoadAck, oLoadBusy, oLoadDone, oAddressError}); end
    Reset = 1'b0;
  endtask

  task automatic test_load();
    logic [31:0] h [4];
    h[0] = 32'h11111111; h[1] = 32'h22222222; h[2] = 32'h33333333; h[3] = 32'h44444444;
    start_load(16'h0010, 16'd2);
    checks++; if (oLoadBusy !== 1'b1) begin failures++; $display("FAIL load_busy_start: got %b expected 1", oLoadBusy); end
    for (int i = 0; i < 4; i++) begin
      send_half(h[i], 0, ack, gapAck);
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL load_ack_%0d: got %b expected 1", i, ack); end
    end
    checks++; if (oLoadDone !== 1'b1 || oLoadBusy !== 1'b1) begin failures++; $display("FAIL load_done_pulse: done=%b busy=%b expected 1 1", oLoadDone, oLoadBusy); end
    step();
    checks++; if (oLoadDone !== 1'b0 || oLoadBusy !== 1'b0) begin failures++; $display("FAIL load_done_end: done=%b busy=%b expected 0 0", oLoadDone, oLoadBusy); end
    shadow[16'h0010] = 64'h2222222211111111;
    shadow[16'h0011] = 64'h4444444433333333;
  endtask

  task automatic test_read_latency();
    logic [15:0] a1 [5];
    logic [15:0] a2 [5];
    a1[0] = 16'h10; a2[0] = 16'h11;
    a1[1] = 16'h11; a2[1] = 16'h10;
    a1[2] = 16'h10; a2[2] = 16'h10;
    a1[3] = 16'h11; a2[3] = 16'h11;
    a1[4] = 16'h10; a2[4] = 16'h11;
    for (int i = 0; i < 5; i++) begin
      drive_read(a1[i], a2[i], $sformatf("read_latency_%0d", i));
      step();
      e = sb.pop_front();
      checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
    end
  endtask

  task automatic test_valid_gaps();
    iLoadValid = 1'b1;
    #1;
    checks++; if (oLoadAck !== 1'b0) begin failures++; $display("FAIL ack_idle: got %b expected 0", oLoadAck); end
    iLoadValid = 1'b0;
    start_load(16'h0020, 16'd1);
    send_half(32'hAAAA5555, 0, ack, gapAck);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL gaps_ack_lo: got %b expected 1", ack); end
    send_half(32'h0F0F0F0F, 2, ack, gapAck);
    checks++; if (gapAck !== 1'b0 || ack !== 1'b1) begin failures++; $display("FAIL gaps_ack_hi: gapAck=%b ack=%b expected 0 1", gapAck, ack); end
    iLoadValid = 1'b1;
    #1;
    checks++; if (oLoadAck !== 1'b0 || oLoadDone !== 1'b1) begin failures++; $display("FAIL gaps_done_state: ack=%b done=%b expected 0 1", oLoadAck, oLoadDone); end
    iLoadValid = 1'b0;
    step();
    shadow[16'h0020] = 64'h0F0F0F0FAAAA5555;
    drive_read(16'h0020, 16'h0010, "gaps_word");
    step();
    e = sb.pop_front();
    checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
  endtask

  task automatic test_out_of_range();
    checks++; if (oAddressError !== 1'b0) begin failures++; $display("FAIL oor_pre: err=%b expected 0", oAddressError); end
    drive_read(16'h0400, 16'h0010, "oor_read");
    step();
    e = sb.pop_front();
    checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
    for (int i = 0; i < 3; i++) begin
      drive_read(16'h0010, 16'h0011, "oor_after");
      step();
      e = sb.pop_front();
      checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2 || oAddressError !== 1'b1) begin failures++; $display("FAIL %s_%0d: got %h %h err=%b expected %h %h err=1", e.tag, i, oInstruction1, oInstruction2, oAddressError, e.e1, e.e2); end
    end
  endtask

  task automatic test_reset_mid_burst();
    start_load(16'h0030, 16'd1);
    send_half(32'hDEADBEEF, 0, ack, gapAck);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if ({oLoadBusy, oLoadDone, oAddressError} !== 3'b000 || oInstruction1 !== 64'h0 || oInstruction2 !== 64'h0) begin failures++; $display("FAIL midreset_state: busy/done/err=%b out=%h %h expected 000 0 0", {oLoadBusy, oLoadDone, oAddressError}, oInstruction1, oInstruction2); end
    iLoadValid = 1'b1;
    #1;
    checks++; if (oLoadAck !== 1'b0) begin failures++; $display("FAIL midreset_ack: got %b expected 0", oLoadAck); end
    iLoadValid = 1'b0;
    step();
    start_load(16'h0030, 16'd1);
    send_half(32'hAAAA0001, 0, ack, gapAck);
    send_half(32'hBBBB0002, 0, ack, gapAck);
    step();
    shadow[16'h0030] = 64'hBBBB0002AAAA0001;
    drive_read(16'h0030, 16'h0010, "midreset_word");
    step();
    e = sb.pop_front();
    checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
  endtask

  task automatic test_write_range();
    start_load(16'h0000, 16'd1);
    send_half(32'h5A5A5A5A, 0, ack, gapAck);
    send_half(32'hA5A5A5A5, 0, ack, gapAck);
    step();
    shadow[16'h0000] = 64'hA5A5A5A55A5A5A5A;
    start_load(16'h03FF, 16'd2);
    send_half(32'h01010101, 0, ack, gapAck);
    send_half(32'h02020202, 0, ack, gapAck);
    checks++; if (oAddressError !== 1'b0) begin failures++; $display("FAIL wr_edge_inrange: err=%b expected 0", oAddressError); end
    send_half(32'h03030303, 0, ack, gapAck);
    send_half(32'h04040404, 0, ack, gapAck);
    checks++; if (oAddressError !== 1'b1 || oLoadDone !== 1'b1) begin failures++; $display("FAIL wr_oor_flag: err=%b done=%b expected 1 1", oAddressError, oLoadDone); end
    step();
    shadow[16'h03FF] = 64'h0202020201010101;
    drive_read(16'h03FF, 16'h0000, "wr_oor_dropped");
    step();
    e = sb.pop_front();
    checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
  endtask

  task automatic test_zero_count();
    start_load(16'h0040, 16'd1);
    send_half(32'h40404040, 0, ack, gapAck);
    send_half(32'h41414141, 0, ack, gapAck);
    step();
    shadow[16'h0040] = 64'h4141414140404040;
    iLoadValid = 1'b1;
    iLoadData  = 32'hFFFFFFFF;
    start_load(16'h0040, 16'd0);
    checks++; if (oLoadDone !== 1'b1 || oLoadBusy !== 1'b0 || oLoadAck !== 1'b0) begin failures++; $display("FAIL zero_done: done=%b busy=%b ack=%b expected 1 0 0", oLoadDone, oLoadBusy, oLoadAck); end
    step();
    checks++; if (oLoadDone !== 1'b0 || oLoadBusy !== 1'b0) begin failures++; $display("FAIL zero_done_end: done=%b busy=%b expected 0 0", oLoadDone, oLoadBusy); end
    iLoadValid = 1'b0;
    drive_read(16'h0040, 16'h0040, "zero_no_write");
    step();
    e = sb.pop_front();
    checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
  endtask

  task automatic test_collision();
    logic [63:0] oldW;
    logic [63:0] newW;
    logic [63:0] m10;
    oldW = shadow[16'h0040];
    newW = 64'h5252525250505050;
    m10  = shadow[16'h0010];
    iAddress1 = 16'h0040;
    iAddress2 = 16'h0010;
    push_exp(oldW, m10, "coll_start");
`ifdef IMEM_WRITE_BYPASS_EN
    push_exp(oldW, m10, "coll_lo");
    push_exp(newW, m10, "coll_hi");
    push_exp(newW, m10, "coll_done");
`else
    push_exp(64'h0, 64'h0, "coll_lo");
    push_exp(64'h0, 64'h0, "coll_hi");
    push_exp(64'h0, 64'h0, "coll_done");
`endif
    push_exp(newW, m10, "coll_idle");
    start_load(16'h0040, 16'd1);
    e = sb.pop_front();
    checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
    send_half(32'h50505050, 0, ack, gapAck);
    e = sb.pop_front();
    checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
    send_half(32'h52525252, 0, ack, gapAck);
    e = sb.pop_front();
    checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
    for (int i = 0; i < 2; i++) begin
      step();
      e = sb.pop_front();
      checks++; if (oInstruction1 !== e.e1 || oInstruction2 !== e.e2) begin failures++; $display("FAIL %s: got %h %h expected %h %h", e.tag, oInstruction1, oInstruction2, e.e1, e.e2); end
    end
    shadow[16'h0040] = newW;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_read_latency();
    test_valid_gaps();
    test_out_of_range();
    test_reset_mid_burst();
    test_write_range();
    test_zero_count();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
